// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - mode codes, FSM states and mode helper shared by univ_shift_reg
package univ_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

// File: rtl/reg_bit_cell.sv
// rtl/reg_bit_cell.sv - one register bit holding q and its complement qb, async active-high reset
module reg_bit_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_next,
  output logic q,
  output logic qb
);

  // qb is its own flop fed from the same next-value, so it never lags q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= RST_BIT;
      qb <= ~RST_BIT;
    end else begin
      q  <= d_next;
      qb <= ~d_next;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst shift engine and busy/done handshake
// Optional parity output enabled by UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               MAX_AMT = 15,
  localparam int              AW      = $clog2(MAX_AMT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
  ,
  output logic             par
`endif
);
  import univ_reg_pkg::*;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [2:0]       lat_mode;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_next;
  logic             zero_burst;

  assign zero_burst = (state == ST_IDLE) && start && is_shift_mode(mode) && (amt == '0);

  always_comb begin
    op_mode = (state == ST_SHIFT) ? lat_mode : mode;
    q_next  = q;
    case (op_mode)
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      default:   q_next = q;
    endcase
    if ((state == ST_DONE) || zero_burst)
      q_next = q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_bit_cell #(.RST_BIT(RST_VAL[i])) u_cell (
      .clk    (clk),
      .rst    (rst),
      .d_next (q_next[i]),
      .q      (q[i]),
      .qb     (qb[i])
    );
  end

`ifdef UNIV_SHIFT_REG_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par <= ^RST_VAL;
    else     par <= ^q_next;
  end
`endif

  // The accepting edge already performs shift #1, so cnt holds the shifts still to go
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_mode <= MODE_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start && is_shift_mode(mode)) begin
            lat_mode <= mode;
            if (amt <= AW'(1)) begin
              state <= ST_DONE;
              cnt   <= '0;
              done  <= 1'b1;
            end else begin
              state <= ST_SHIFT;
              cnt   <= amt - AW'(1);
              busy  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt == AW'(1)) begin
            state <= ST_DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - AW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
